// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared fetch-stage state encodings and PC defaults
package pc_unit_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;
  localparam int CONTADOR_LENGTH_DEF = 11;
  localparam int PC_INCREMENT_DEF = 1;
endpackage

// File: rtl/pc_unit_next_mux.sv
// pc_next_mux: priority select of the next PC (halt/stall > jump > branch > increment)
module pc_next_mux #(
  parameter int W = 11
) (
  input  logic         advance,
  input  logic         halt,
  input  logic         stall,
  input  logic         jump,
  input  logic [W-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] pc_plus,
  output logic [W-1:0] next_pc
);
  // Hold unless the cycle advances without halt or stall; jump outranks branch.
  always_comb
    next_pc = (!advance || halt || stall) ? pc :
              jump ? jump_target :
              branch_taken ? branch_target : pc_plus;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC register with step/stall/halt control and saturating cycle counter
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int CONTADOR_LENGTH = CONTADOR_LENGTH_DEF,
  parameter int PC_INCREMENT = PC_INCREMENT_DEF,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                       i_clock,
  input  logic                       i_soft_reset,
  input  logic                       i_enable,
  input  logic                       i_modo_step,
  input  logic                       i_step,
  input  logic                       i_stall,
  input  logic                       i_branch_taken,
  input  logic [CONTADOR_LENGTH-1:0] i_branch_target,
  input  logic                       i_jump,
  input  logic [CONTADOR_LENGTH-1:0] i_jump_target,
  input  logic                       i_halt,
  output logic [CONTADOR_LENGTH-1:0] o_direccion,
  output logic [CONTADOR_LENGTH-1:0] o_direccion_plus,
  output logic                       o_halted,
  output logic [COUNT_WIDTH-1:0]     o_ciclos
);
  state_t state, state_next;
  logic advance;
  logic [CONTADOR_LENGTH-1:0] pc_next;

  assign advance = i_enable & (~i_modo_step | i_step) & (state == ST_RUN);
  assign o_direccion_plus = o_direccion + CONTADOR_LENGTH'(PC_INCREMENT);
  assign o_halted = (state == ST_HALTED);

  pc_next_mux #(.W(CONTADOR_LENGTH)) u_mux (
    .advance(advance),
    .halt(i_halt),
    .stall(i_stall),
    .jump(i_jump),
    .jump_target(i_jump_target),
    .branch_taken(i_branch_taken),
    .branch_target(i_branch_target),
    .pc(o_direccion),
    .pc_plus(o_direccion_plus),
    .next_pc(pc_next)
  );

  // HALTED is entered on an advancing halt cycle and left only by reset.
  always_comb
    state_next = (advance && i_halt) ? ST_HALTED : state;

  // State, PC and saturating counter registers.
  always_ff @(posedge i_clock or negedge i_soft_reset)
    if (!i_soft_reset) begin
      state <= ST_RUN;
      o_direccion <= '0;
      o_ciclos <= '0;
    end else begin
      state <= state_next;
      o_direccion <= pc_next;
      if (advance && !(&o_ciclos)) o_ciclos <= o_ciclos + COUNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit (11-bit/32-bit and 3-bit/4-bit instances)
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n, en, modo, step, stall, br, jmp, halt;
  logic [10:0] br_t, jmp_t, pc, pc_plus;
  logic halted;
  logic [31:0] ciclos;
  logic s_en, s_jmp;
  logic [2:0] s_jmp_t, s_pc, s_pc_plus;
  logic s_halted;
  logic [3:0] s_ciclos;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .i_clock(clk), .i_soft_reset(rst_n), .i_enable(en), .i_modo_step(modo),
    .i_step(step), .i_stall(stall), .i_branch_taken(br), .i_branch_target(br_t),
    .i_jump(jmp), .i_jump_target(jmp_t), .i_halt(halt),
    .o_direccion(pc), .o_direccion_plus(pc_plus), .o_halted(halted), .o_ciclos(ciclos)
  );

  pc_unit #(.CONTADOR_LENGTH(3), .PC_INCREMENT(1), .COUNT_WIDTH(4)) dut_s (
    .i_clock(clk), .i_soft_reset(rst_n), .i_enable(s_en), .i_modo_step(1'b0),
    .i_step(1'b0), .i_stall(1'b0), .i_branch_taken(1'b0), .i_branch_target(3'd0),
    .i_jump(s_jmp), .i_jump_target(s_jmp_t), .i_halt(1'b0),
    .o_direccion(s_pc), .o_direccion_plus(s_pc_plus), .o_halted(s_halted), .o_ciclos(s_ciclos)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 0; en = 0; modo = 0; step = 0; stall = 0; br = 0; jmp = 0; halt = 0;
    br_t = 0; jmp_t = 0; s_en = 0; s_jmp = 0; s_jmp_t = 0;
    tick(2);
    rst_n = 1;
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ciclos", ciclos, 0);
    en = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("run_pc%0d", i), pc, i);
    end
    chk("run_ciclos", ciclos, 4);
    chk("run_plus", pc_plus, 5);
    tick();
    chk("pre_rst_pc", pc, 5);
    rst_n = 0;
    en = 0;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_halted", halted, 0);
    chk("async_rst_ciclos", ciclos, 0);
    tick();
    rst_n = 1;
    en = 1; jmp = 1; jmp_t = 11'h10;
    tick();
    chk("jump_pc", pc, 11'h10);
    jmp_t = 11'h40; br = 1; br_t = 11'h20;
    tick();
    chk("jump_over_branch", pc, 11'h40);
    chk("jump_ciclos", ciclos, 2);
    jmp_t = 11'h10; br = 0;
    tick();
    jmp_t = 11'h40; br = 1; stall = 1;
    tick();
    chk("stall_pc", pc, 11'h10);
    chk("stall_ciclos", ciclos, 4);
    stall = 0; jmp = 0;
    tick();
    chk("branch_pc", pc, 11'h20);
    br = 0; modo = 1;
    tick(10);
    chk("step_idle_pc", pc, 11'h20);
    chk("step_idle_ciclos", ciclos, 5);
    step = 1;
    tick();
    step = 0;
    chk("step1_pc", pc, 11'h21);
    tick();
    step = 1;
    tick();
    step = 0;
    chk("step2_pc", pc, 11'h22);
    chk("step2_ciclos", ciclos, 7);
    modo = 0; jmp = 1; jmp_t = 11'h08;
    tick();
    chk("pre_halt_pc", pc, 11'h08);
    halt = 1; jmp_t = 11'h40;
    tick();
    halt = 0; jmp = 0;
    chk("halt_pc", pc, 11'h08);
    chk("halt_flag", halted, 1);
    chk("halt_ciclos", ciclos, 9);
    tick(20);
    chk("halted_pc", pc, 11'h08);
    chk("halted_flag", halted, 1);
    chk("halted_ciclos", ciclos, 9);
    rst_n = 0;
    #1;
    chk("halt_rst_pc", pc, 0);
    chk("halt_rst_flag", halted, 0);
    tick();
    rst_n = 1; en = 0;
    tick();
    chk("post_rst_pc", pc, 0);
    s_en = 1; s_jmp = 1; s_jmp_t = 3'd7;
    tick();
    s_jmp = 0;
    chk("s_pc7", s_pc, 7);
    chk("s_plus_wrap", s_pc_plus, 0);
    tick();
    chk("s_wrap_pc", s_pc, 0);
    tick(18);
    chk("s_sat_ciclos", s_ciclos, 15);
    chk("s_sat_pc", s_pc, 2);
    chk("s_halted", s_halted, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage, successor to the plain enable-gated PC register. It owns the PC register and selects the next PC among sequential increment, branch target and jump target. It supports hazard stalls, a debug single-step mode and a halt state, and keeps a saturating cycle counter that the debug unit reads out. It sits between the hazard/branch logic in decode and the instruction memory address port.

## Interface
Parameters:
- CONTADOR_LENGTH, 11, PC width in bits (word address into instruction memory).
- PC_INCREMENT, 1, sequential step added to the PC.
- COUNT_WIDTH, 32, cycle counter width.

Ports (one clock; reset is asynchronous and active-low):
- i_clock  in  1  clock; all state updates on rising edge.
- i_soft_reset  in  1  asynchronous active-low reset.
- i_enable  in  1  global run enable from the debug unit.
- i_modo_step  in  1  1 = single-step mode; the PC advances only on i_step.
- i_step  in  1  one-cycle step pulse, used only when i_modo_step=1.
- i_stall  in  1  hazard stall; the PC holds.
- i_branch_taken  in  1  take i_branch_target.
- i_branch_target  in  CONTADOR_LENGTH  branch destination.
- i_jump  in  1  take i_jump_target.
- i_jump_target  in  CONTADOR_LENGTH  jump destination.
- i_halt  in  1  halt instruction present at the current PC.
- o_direccion  out  CONTADOR_LENGTH  current PC (registered).
- o_direccion_plus  out  CONTADOR_LENGTH  o_direccion + PC_INCREMENT (combinational, mod 2^CONTADOR_LENGTH).
- o_halted  out  1  unit is in HALTED.
- o_ciclos  out  COUNT_WIDTH  count of advance-qualified cycles.

## Operation
- States: RUN, HALTED. Reset enters RUN.
- advance = i_enable & (~i_modo_step | i_step) & state==RUN.
- In RUN with advance=1:
  - i_halt=1: the PC holds and the state goes to HALTED. i_halt has priority over stall, jump and branch.
  - else i_stall=1: the PC holds.
  - else i_jump=1: PC <= i_jump_target.
  - else i_branch_taken=1: PC <= i_branch_target.
  - else: PC <= o_direccion_plus.
- With advance=0, the PC holds regardless of the other inputs.
- HALTED is sticky. Only reset leaves it; the PC stays frozen at the halt address.
- o_ciclos increments on every cycle with advance=1, including stall cycles and the halting cycle. It saturates at all-ones and does not wrap.
- Increment arithmetic is modulo 2^CONTADOR_LENGTH: the PC wraps from max to 0 silently.
- Simultaneous i_jump and i_branch_taken: jump wins.

## Timing
- Reset, asynchronous and immediate: o_direccion=0, o_halted=0, o_ciclos=0, state=RUN.
- Reset deassertion is released synchronously in effect; the first update occurs on the first rising edge with i_soft_reset=1.
- Latency: a redirect or increment qualified on edge N is visible on o_direccion right after edge N (one cycle).
- o_halted rises one cycle after the edge that samples i_halt with advance=1.
- Step mode: each i_step pulse produces exactly one update. An i_step held high for k cycles produces k updates; debouncing is upstream.
- Mid-operation reset overrides everything, including HALTED.

## Structure
- Shared MIPS package holds:
  - state encodings ST_RUN and ST_HALTED (1 bit);
  - default CONTADOR_LENGTH;
  - PC_INCREMENT.
- Sub-module: pc_next_mux, the combinational next-PC priority select (halt/stall/jump/branch/increment).
- Top level holds the PC register, the state FF and the saturating counter.

## Test plan
- Reset mid-run with PC=0x05: o_direccion=0, o_halted=0 and o_ciclos=0 immediately, before any clock edge.
- Free run from 0, i_enable=1, 4 cycles: PC sequence 1,2,3,4 and o_ciclos=4. With CONTADOR_LENGTH=3, starting at 7: next PC is 0.
- PC=0x10, i_jump=1 (target 0x40) and i_branch_taken=1 (target 0x20) in the same cycle: next PC=0x40. Same cycle with i_stall=1 instead: PC stays 0x10 and o_ciclos still increments.
- i_modo_step=1 with no i_step for 10 cycles: PC and o_ciclos unchanged. Two single-cycle i_step pulses: PC +2, o_ciclos +2.
- PC=0x08, i_halt=1 together with i_jump=1: PC stays 0x08 and o_halted=1 next cycle. It stays so for 20 more cycles with o_ciclos frozen; reset returns to 0/RUN.
- COUNT_WIDTH=4 run for 20 advance cycles: o_ciclos saturates at 15.
